// File: rtl/fifo_serial_pkg.sv
// fifo_serial_pkg: shared FSM state encoding and counter width helper for fifo_serial_tx
package fifo_serial_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/fifo_serial_tx_baud.sv
// baud_counter: per-bit terminal-count tick every CLKS_PER_BIT cycles with synchronous clear
module baud_counter
   import fifo_serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);
   localparam int W = cnt_w(CLKS_PER_BIT);
   logic [W-1:0] cnt;
   assign tick = cnt == W'(CLKS_PER_BIT - 1);
   always_ff @(posedge clk)
      if (!reset || clr || tick) cnt <= '0;
      else cnt <= cnt + W'(1);
endmodule

// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: FWFT FIFO to serial frame transmitter; define FIFO_SERIAL_TX_PARITY_EN to add an even parity bit
module fifo_serial_tx
   import fifo_serial_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  empty,
   input  logic [DATA_WIDTH-1:0] r_data,
   output logic                  rd,
   output logic                  tx,
   output logic                  busy
);
   localparam logic [2:0] IDLE  = ST_IDLE;
   localparam logic [2:0] START = ST_START;
   localparam logic [2:0] DATA  = ST_DATA;
   localparam logic [2:0] STOP  = ST_STOP;
`ifdef FIFO_SERIAL_TX_PARITY_EN
   localparam logic [2:0] PARITY = ST_PARITY;
   localparam logic [2:0] AFTER_DATA = PARITY;
`else
   localparam logic [2:0] AFTER_DATA = STOP;
`endif
   localparam int IW = cnt_w(DATA_WIDTH);
   logic [2:0]            state;
   logic [DATA_WIDTH-1:0] shreg;
   logic [IW-1:0]         idx;
   logic                  tick, go, last;
   baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk  (clk),
      .reset(reset),
      .clr  (state == IDLE),
      .tick (tick)
   );
   assign go   = reset && en && !empty && (state == IDLE || (state == STOP && tick));
   assign rd   = go;
   assign busy = state != IDLE;
   assign last = idx == IW'(DATA_WIDTH - 1);
`ifdef FIFO_SERIAL_TX_PARITY_EN
   logic par;
   always_ff @(posedge clk)
      if (!reset) par <= 1'b0;
      else if (go) par <= ^r_data;
`endif
   always_comb begin
      tx = 1'b1;
      if (state == START) tx = 1'b0;
      else if (state == DATA) tx = shreg[0];
`ifdef FIFO_SERIAL_TX_PARITY_EN
      else if (state == PARITY) tx = par;
`endif
   end
   always_ff @(posedge clk)
      if (!reset) begin
         state <= IDLE;
         shreg <= '0;
         idx   <= '0;
      end else if (go) begin
         state <= START;
         shreg <= r_data;
         idx   <= '0;
      end else if (tick) begin
         if (state == START) state <= DATA;
         else if (state == DATA) begin
            shreg <= shreg >> 1;
            idx   <= last ? '0 : idx + IW'(1);
            if (last) state <= AFTER_DATA;
         end
`ifdef FIFO_SERIAL_TX_PARITY_EN
         else if (state == PARITY) state <= STOP;
`endif
         else if (state == STOP) state <= IDLE;
      end
endmodule

// File: tb/tb_fifo_serial_tx.sv
// tb_fifo_serial_tx: table-driven frame checks of fifo_serial_tx against a bench-side FWFT FIFO model
module tb_fifo_serial_tx;
   localparam int CPB = 4;
`ifdef FIFO_SERIAL_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME = NB * CPB;
   typedef struct {
      logic [7:0] d;
      logic [9:0] pat;
      logic       par;
   } vec_t;
   logic       clk = 0, reset = 0, en = 0, empty = 1;
   logic [7:0] r_data = 0;
   logic       rd, tx, busy, rd_s;
   logic [7:0] q[$];
   vec_t       tbl[9];
   int         checks = 0, errors = 0, cyc = 0, rd_cnt = 0, rd_cyc = 0, rd_cyc_prev = 0;
   fifo_serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .empty (empty),
      .r_data(r_data),
      .rd    (rd),
      .tx    (tx),
      .busy  (busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask
   function automatic void upd();
      empty  = q.size() == 0;
      r_data = empty ? 8'h00 : q[0];
   endfunction
   task automatic push(input logic [7:0] d);
      q.push_back(d);
      upd();
   endtask
   always @(negedge clk) begin
      #2;
      rd_s = rd;
      if (rd) chk("rd_while_empty", empty, 0);
   end
   always @(posedge clk) begin
      cyc++;
      #1;
      if (rd_s) begin
         rd_cnt++;
         if (q.size() > 0) void'(q.pop_front());
         upd();
      end
   end
   task automatic wait_rd(output int k, output bit ok);
      k = 0;
      #1;
      while (!rd && k < 100) begin
         @(negedge clk);
         #1;
         k++;
      end
      ok = rd;
      chk("rd_seen", rd, 1);
      rd_cyc_prev = rd_cyc;
      rd_cyc = cyc;
   endtask
   task automatic check_frame(input vec_t v, output int k);
      logic [10:0] pat;
      bit ok;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      pat = {1'b1, v.par, v.pat[8:0]};
`else
      pat = {1'b0, v.pat};
`endif
      wait_rd(k, ok);
      if (!ok) return;
      for (int b = 0; b < NB; b++)
         for (int c = 0; c < CPB; c++) begin
            @(negedge clk);
            if (b == NB - 1 && c == CPB - 1)
               chk($sformatf("frame_%02h_bit%0d", v.d, b), {busy, tx}, {1'b1, pat[b]});
            else
               chk($sformatf("frame_%02h_bit%0d", v.d, b), {busy, tx, rd}, {1'b1, pat[b], 1'b0});
         end
   endtask
   initial begin
      int k;
      bit ok;
      tbl[0] = '{8'hA5, 10'b1101001010, 1'b0};
      tbl[1] = '{8'h0F, 10'b1000011110, 1'b0};
      tbl[2] = '{8'hF0, 10'b1111100000, 1'b0};
      tbl[3] = '{8'h07, 10'b1000001110, 1'b1};
      tbl[4] = '{8'h03, 10'b1000000110, 1'b0};
      tbl[5] = '{8'h55, 10'b1010101010, 1'b0};
      tbl[6] = '{8'h66, 10'b1011001100, 1'b0};
      tbl[7] = '{8'hAA, 10'b1101010100, 1'b0};
      tbl[8] = '{8'hFF, 10'b1111111110, 1'b0};
      repeat (2) begin
         @(negedge clk);
         chk("rst_idle", {busy, tx, rd}, 3'b010);
      end
      reset = 1;
      repeat (3) begin
         @(negedge clk);
         chk("idle_empty", {busy, tx, rd}, 3'b010);
      end
      en = 1;
      push(tbl[0].d);
      check_frame(tbl[0], k);
      chk("a5_latency", k, 0);
      @(negedge clk);
      chk("a5_end_idle", {busy, tx, rd}, 3'b010);
      chk("a5_rd_count", rd_cnt, 1);
      for (int i = 1; i <= 4; i++) push(tbl[i].d);
      for (int i = 1; i <= 4; i++) begin
         check_frame(tbl[i], k);
         chk("b2b_wait", k, 0);
         if (i > 1) chk("b2b_rd_gap", rd_cyc - rd_cyc_prev, FRAME);
      end
      @(negedge clk);
      chk("b2b_end_idle", {busy, tx, rd}, 3'b010);
      chk("b2b_rd_count", rd_cnt, 5);
      en = 0;
      push(tbl[5].d);
      push(tbl[6].d);
      repeat (6) begin
         @(negedge clk);
         chk("gate_hold", {busy, tx, rd}, 3'b010);
      end
      en = 1;
      fork
         check_frame(tbl[5], k);
         begin
            repeat (12) @(negedge clk);
            en = 0;
         end
      join
      chk("gate_latency", k, 0);
      repeat (8) begin
         @(negedge clk);
         chk("gate_no_restart", {busy, tx, rd}, 3'b010);
      end
      chk("gate_rd_count", rd_cnt, 6);
      en = 1;
      check_frame(tbl[6], k);
      chk("gate_resume", k, 0);
      @(negedge clk);
      push(tbl[8].d);
      push(tbl[7].d);
      wait_rd(k, ok);
      repeat (18) @(negedge clk);
      chk("pre_reset_bit3", {busy, tx}, 2'b11);
      reset = 0;
      repeat (2) begin
         @(negedge clk);
         chk("mid_reset", {busy, tx, rd}, 3'b010);
      end
      chk("mid_reset_rd_count", rd_cnt, 8);
      reset = 1;
      check_frame(tbl[7], k);
      chk("post_reset_latency", k, 0);
      @(negedge clk);
      chk("final_idle", {busy, tx, rd}, 3'b010);
      chk("final_rd_count", rd_cnt, 9);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fifo_serial_tx.md
FIFO_SERIAL_TX -- requirements
Module: fifo_serial_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of r_data and of the serial payload.
REQ-002 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range 2..65535.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: reset, synchronous, active-low.
REQ-005 Port en, input, 1: when high, new frames may start.
REQ-006 Port empty, input, 1: upstream FWFT FIFO empty flag.
REQ-007 Port r_data, input, DATA_WIDTH: upstream FWFT FIFO head value, valid whenever empty is low.
REQ-008 Port rd, output, 1: single-cycle pop strobe to the upstream FIFO.
REQ-009 Port tx, output, 1: serial line, idle high.
REQ-010 Port busy, output, 1: high in every non-IDLE state.

Function
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP; PARITY is present only per REQ-027.
REQ-012 In IDLE with en=1 and empty=0, the block SHALL latch r_data into a shift register, assert rd for exactly that cycle, and enter START next cycle.
REQ-013 rd SHALL never be asserted while empty=1, and SHALL be asserted at most once per frame.
REQ-014 Each state SHALL hold tx constant for exactly CLKS_PER_BIT cycles, timed by a bit counter that restarts on every state or bit change.
REQ-015 tx levels: START=0; DATA drives shift-register bits LSB first, DATA_WIDTH bits; STOP=1; IDLE=1.
REQ-016 Frame length SHALL be (DATA_WIDTH+2)*CLKS_PER_BIT cycles without parity, and (DATA_WIDTH+3)*CLKS_PER_BIT cycles with parity.
REQ-017 Back-to-back operation: in the last STOP cycle, with en=1 and empty=0, the block SHALL latch r_data, pulse rd, and enter START next cycle with zero idle gap. Otherwise it SHALL go to IDLE.
REQ-018 en deasserted mid-frame SHALL NOT abort the frame; it only blocks the next frame start.
REQ-019 r_data and empty changes during a frame SHALL NOT affect the frame in progress.
REQ-020 The bit-index counter SHALL be $clog2(DATA_WIDTH) bits wide and SHALL leave DATA after index DATA_WIDTH-1 without wrap-around error.
REQ-021 An upstream push while empty=1 and the block is IDLE SHALL be accepted on the first cycle that empty=0 is sampled.

Reset
REQ-022 While reset=0 at a clock edge: state IDLE, tx=1, rd=0, busy=0, all counters 0, shift register 0.
REQ-023 Reset mid-frame SHALL abandon the frame immediately (tx=1 next cycle); the already-popped word is lost and SHALL NOT be re-read.
REQ-024 The first frame after release SHALL start no earlier than the first edge with reset=1.

Configuration
REQ-025 Macro FIFO_SERIAL_TX_PARITY_EN SHALL select parity support at compile time.
REQ-026 Without FIFO_SERIAL_TX_PARITY_EN: no PARITY state exists and STOP follows the last DATA bit.
REQ-027 With FIFO_SERIAL_TX_PARITY_EN: a PARITY bit follows DATA and carries even parity, equal to the XOR of all DATA_WIDTH payload bits, for CLKS_PER_BIT cycles.

Structure
REQ-028 Package fifo_serial_pkg SHALL hold the state enum typedef and a localparam function for counter widths.
REQ-029 One sub-module, baud_counter, SHALL generate the per-bit terminal-count tick from CLKS_PER_BIT with a synchronous clear.
REQ-030 The block SHALL connect directly to the 8-bit FWFT FIFO read side (rd, empty, r_data) with no glue logic.

Verification (bench: DATA_WIDTH=8, CLKS_PER_BIT=4)
REQ-031 Reset then idle: reset=0 for 2 cycles, empty=1 -> tx=1, rd=0, busy=0 on every cycle.
REQ-032 Single frame: empty=0 with r_data=8'hA5 for 1 cycle, en=1 -> rd pulses once; tx = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles; frame is 40 cycles (44 with parity, parity bit 0).
REQ-033 Back-to-back: FIFO holds 8'h0F then 8'hF0 -> the second START begins the cycle after the first STOP ends; rd pulses twice, 40 cycles apart.
REQ-034 en gating: en=0 with empty=0 -> no rd and tx=1; en=1 -> frame starts next cycle; en dropped mid-frame -> frame completes, no new rd.
REQ-035 Reset mid-frame: assert reset=0 during the DATA bit 3 of 8'hFF -> tx=1 next cycle; on release with empty=0 the next FIFO word (not 8'hFF) is sent.
REQ-036 Parity build: with FIFO_SERIAL_TX_PARITY_EN, send 8'h07 -> parity bit = 1; send 8'h03 -> parity bit = 0.
